// File: rtl/word_pkg.sv
// Shared types for the word buffer: letter codes, edit ops, FSM states.
package word_pkg;

  localparam int DEFAULT_MAX_LEN = 10;

  typedef logic [5:0] letter_t;

  localparam letter_t BLANK_CODE = 6'd0;

  typedef enum logic [1:0] {
    OP_APPEND    = 2'b00,
    OP_BACKSPACE = 2'b01,
    OP_CLEAR     = 2'b10,
    OP_RSVD      = 2'b11
  } op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

endpackage

// File: rtl/word_publish.sv
// Frame-synchronous copy of the shadow word into the display-stable array.
module word_publish
  import word_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  letter_t i_shadow [MAX_LEN-1:0],
  input  logic    i_mod,
  input  logic    i_new_frame,
  output letter_t o_word   [MAX_LEN-1:0]
);

  logic    r_dirty;
  letter_t r_word [MAX_LEN-1:0];

  // The shadow seen here is pre-edge, so a same-edge edit lands next frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dirty <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) r_word[i] <= BLANK_CODE;
    end else begin
      if (i_new_frame && r_dirty) begin
        for (int i = 0; i < MAX_LEN; i++) r_word[i] <= i_shadow[i];
      end
      if (i_mod)            r_dirty <= 1'b1;
      else if (i_new_frame) r_dirty <= 1'b0;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/word_buffer.sv
// Edits a shadow word from an append/backspace/clear stream; publishes per frame.
// Optional WORD_BUFFER_SCROLL_EN: full-buffer appends scroll left instead of dropping.
module word_buffer
  import word_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  letter_t       letter_in,
  input  logic [1:0]    op_in,
  input  logic          valid_in,
  output logic          ready_out,
  input  logic          new_frame_in,
  output letter_t       word_out [MAX_LEN-1:0],
  output logic [LW-1:0] len_out,
  output logic          overflow_out
);

  state_t        r_state;
  letter_t       r_shadow [MAX_LEN-1:0];
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_idx;
  logic          r_ovf;

  logic w_acc;
  logic w_full;
  logic w_last;
  logic w_mod;
  op_t  w_op;

  assign w_op   = op_t'(op_in);
  assign w_acc  = valid_in && (r_state == IDLE);
  assign w_full = (r_len == LW'(MAX_LEN));
  assign w_last = (r_idx == LW'(MAX_LEN - 1));

  always_comb begin
    w_mod = 1'b0;
    if (w_acc) begin
      unique case (w_op)
        OP_APPEND: begin
`ifdef WORD_BUFFER_SCROLL_EN
          w_mod = 1'b1;
`else
          w_mod = !w_full;
`endif
        end
        OP_BACKSPACE: w_mod = (r_len != '0);
        OP_CLEAR:     w_mod = 1'b0;
        OP_RSVD:      w_mod = 1'b0;
      endcase
    end else if (r_state == CLEARING) begin
      w_mod = w_last;
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) r_shadow[i] <= BLANK_CODE;
    end else begin
      r_ovf <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (valid_in) begin
            unique case (w_op)
              OP_APPEND: begin
                if (!w_full) begin
                  for (int i = 0; i < MAX_LEN; i++)
                    if (LW'(i) == r_len) r_shadow[i] <= letter_in;
                  r_len <= r_len + LW'(1);
                end else begin
`ifdef WORD_BUFFER_SCROLL_EN
                  for (int i = 0; i < MAX_LEN - 1; i++)
                    r_shadow[i] <= r_shadow[i+1];
                  r_shadow[MAX_LEN-1] <= letter_in;
`else
                  r_ovf <= 1'b1;
`endif
                end
              end
              OP_BACKSPACE: begin
                if (r_len != '0) begin
                  for (int i = 0; i < MAX_LEN; i++)
                    if (LW'(i) + LW'(1) == r_len) r_shadow[i] <= BLANK_CODE;
                  r_len <= r_len - LW'(1);
                end
              end
              OP_CLEAR: begin
                r_idx   <= '0;
                r_state <= CLEARING;
              end
              OP_RSVD: ;
            endcase
          end
        end
        CLEARING: begin
          for (int i = 0; i < MAX_LEN; i++)
            if (LW'(i) == r_idx) r_shadow[i] <= BLANK_CODE;
          r_idx <= r_idx + LW'(1);
          if (w_last) begin
            r_len   <= '0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  word_publish #(.MAX_LEN(MAX_LEN)) u_publish (
    .i_clk       (pixel_clk_in),
    .i_rst       (rst_in),
    .i_shadow    (r_shadow),
    .i_mod       (w_mod),
    .i_new_frame (new_frame_in),
    .o_word      (word_out)
  );

  assign ready_out    = (r_state == IDLE);
  assign len_out      = r_len;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_word_buffer.sv
// Directed self-checking bench for word_buffer (default and scroll builds).
module tb_word_buffer;
  import word_pkg::*;

  localparam int ML = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  letter_t    letter = '0;
  logic [1:0] op = 2'b00;
  logic       valid = 1'b0;
  logic       ready;
  logic       frame = 1'b0;
  letter_t    word [ML-1:0];
  logic [3:0] len;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_buffer #(.MAX_LEN(ML)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .letter_in    (letter),
    .op_in        (op),
    .valid_in     (valid),
    .ready_out    (ready),
    .new_frame_in (frame),
    .word_out     (word),
    .len_out      (len),
    .overflow_out (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] o, input letter_t l);
    op = o; letter = l; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    frame = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int first_diff(input letter_t e [ML]);
    for (int i = 0; i < ML; i++)
      if (word[i] !== e[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    letter_t e [ML];
    int k;
    do_reset();
    foreach (e[i]) e[i] = BLANK_CODE;
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", ready);
    end
    checks++;
    if (len !== 4'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_len_ovf got %0d/%b want 0/0", len, ovf);
    end
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL reset_word slot %0d got %0d want 0", k, word[k]);
    end
  endtask

  task automatic test_append();
    letter_t e [ML];
    int k;
    do_reset();
    send(OP_APPEND, 6'd5);
    send(OP_APPEND, 6'd12);
    send(OP_APPEND, 6'd7);
    foreach (e[i]) e[i] = BLANK_CODE;
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL append_prepub slot %0d got %0d want %0d", k, word[k], e[k]);
    end
    checks++;
    if (len !== 4'd3) begin
      errors++; $display("FAIL append_len got %0d want 3", len);
    end
    pulse_frame();
    e[0] = 6'd5; e[1] = 6'd12; e[2] = 6'd7;
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL append_pub slot %0d got %0d want %0d", k, word[k], e[k]);
    end
  endtask

  task automatic test_full();
    letter_t e [ML];
    int k;
    logic ovf1, ovf2;
    do_reset();
    for (int i = 1; i <= ML; i++) send(OP_APPEND, letter_t'(i));
    pulse_frame();
    send(OP_APPEND, 6'd33);
    ovf1 = ovf;
    tick();
    ovf2 = ovf;
    checks++;
    if (len !== 4'd10) begin
      errors++; $display("FAIL full_len got %0d want 10", len);
    end
    pulse_frame();
`ifdef WORD_BUFFER_SCROLL_EN
    checks++;
    if (ovf1 !== 1'b0 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL full_ovf got %b%b want 00", ovf1, ovf2);
    end
    for (int i = 0; i < ML - 1; i++) e[i] = letter_t'(i + 2);
    e[ML-1] = 6'd33;
`else
    checks++;
    if (ovf1 !== 1'b1 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL full_ovf got %b%b want 10", ovf1, ovf2);
    end
    for (int i = 0; i < ML; i++) e[i] = letter_t'(i + 1);
`endif
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL full_word slot %0d got %0d want %0d", k, word[k], e[k]);
    end
  endtask

  task automatic test_backspace();
    letter_t e [ML];
    logic [3:0] want [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
    int k;
    do_reset();
    send(OP_APPEND, 6'd4);
    send(OP_APPEND, 6'd5);
    send(OP_APPEND, 6'd6);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (ready !== 1'b1) begin
        errors++; $display("FAIL bksp_ready[%0d] got %b want 1", n, ready);
      end
      send(OP_BACKSPACE, 6'd0);
      checks++;
      if (len !== want[n]) begin
        errors++; $display("FAIL bksp_len[%0d] got %0d want %0d", n, len, want[n]);
      end
    end
    pulse_frame();
    foreach (e[i]) e[i] = BLANK_CODE;
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL bksp_word slot %0d got %0d want 0", k, word[k]);
    end
  endtask

  task automatic test_clear();
    letter_t e [ML];
    int k;
    int lows;
    logic len_ok;
    do_reset();
    for (int i = 1; i <= 6; i++) send(OP_APPEND, letter_t'(i));
    pulse_frame();
    op = OP_CLEAR; valid = 1'b1;
    tick();
    op = OP_APPEND; letter = 6'd50;
    lows = 0;
    len_ok = 1'b1;
    while (ready === 1'b0 && lows < 30) begin
      if (len !== 4'd6) len_ok = 1'b0;
      lows++;
      tick();
    end
    checks++;
    if (lows != 10) begin
      errors++; $display("FAIL clear_busy got %0d cycles want 10", lows);
    end
    checks++;
    if (!len_ok) begin
      errors++; $display("FAIL clear_len_during got changed want 6");
    end
    checks++;
    if (len !== 4'd0) begin
      errors++; $display("FAIL clear_len got %0d want 0", len);
    end
    tick();
    valid = 1'b0;
    checks++;
    if (len !== 4'd1) begin
      errors++; $display("FAIL clear_held_append got len %0d want 1", len);
    end
    pulse_frame();
    foreach (e[i]) e[i] = BLANK_CODE;
    e[0] = 6'd50;
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL clear_word slot %0d got %0d want %0d", k, word[k], e[k]);
    end
  endtask

  task automatic test_same_edge();
    letter_t e [ML];
    int k;
    do_reset();
    send(OP_APPEND, 6'd1);
    send(OP_APPEND, 6'd2);
    frame = 1'b1;
    send(OP_APPEND, 6'd9);
    frame = 1'b0;
    foreach (e[i]) e[i] = BLANK_CODE;
    e[0] = 6'd1; e[1] = 6'd2;
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL same_edge_pub slot %0d got %0d want %0d", k, word[k], e[k]);
    end
    checks++;
    if (len !== 4'd3) begin
      errors++; $display("FAIL same_edge_len got %0d want 3", len);
    end
    pulse_frame();
    e[2] = 6'd9;
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL same_edge_next slot %0d got %0d want %0d", k, word[k], e[k]);
    end
  endtask

  task automatic test_reset_mid_clear();
    letter_t e [ML];
    int k;
    do_reset();
    send(OP_APPEND, 6'd3);
    send(OP_APPEND, 6'd8);
    send(OP_APPEND, 6'd11);
    pulse_frame();
    send(OP_CLEAR, 6'd0);
    tick();
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL midclr_busy got %b want 0", ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || len !== 4'd0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL midclr_state got rdy %b len %0d ovf %b want 1/0/0", ready, len, ovf);
    end
    foreach (e[i]) e[i] = BLANK_CODE;
    k = first_diff(e);
    checks++;
    if (k >= 0) begin
      errors++; $display("FAIL midclr_word slot %0d got %0d want 0", k, word[k]);
    end
  endtask

  initial begin
    test_reset();
    test_append();
    test_full();
    test_backspace();
    test_clear();
    test_same_edge();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
